// File: rtl/mem_pkg.sv
// Shared types and helpers for the multi-port register-file memory.
package mem_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clearState_t;

   localparam int MaxWidth = 1024;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Value presented on a disabled or out-of-range read port, widened to MaxWidth.
   function automatic logic [MaxWidth-1:0] disabled_value(input bit inverted, input int width);
      logic [MaxWidth-1:0] v;
      v = '0;
      for (int i = 0; i < MaxWidth; i++) begin
         if (inverted && (i < width)) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/multi_read_mem_if.sv
// Write/read bus of the multi-port memory; the master drives requests, the slave returns data.
interface multi_read_mem_if #(
   parameter int BitWidth     = 8,
   parameter int Depth        = 16,
   parameter int NumReadPorts = 2,
   parameter int LaneWidth    = 8
);
   import mem_pkg::*;

   localparam int AW       = addr_width(Depth);
   localparam int NumLanes = BitWidth / LaneWidth;

   logic                                  wEn;
   logic [AW-1:0]                         wAddr;
   logic [NumLanes-1:0]                   wMask;
   logic [BitWidth-1:0]                   dIN;
   logic [NumReadPorts-1:0]               rEn;
   logic [NumReadPorts-1:0][AW-1:0]       rAddr;
   logic [NumReadPorts-1:0][BitWidth-1:0] dOUT;
   logic                                  busy;

   modport master (output wEn, wAddr, wMask, dIN, rEn, rAddr, input dOUT, busy);
   modport slave  (input wEn, wAddr, wMask, dIN, rEn, rAddr, output dOUT, busy);

endinterface

// File: rtl/mem_read_port.sv
// One read port: range check, disabled-value select and optional output register with write-first bypass.
module mem_read_port import mem_pkg::*; #(
   parameter int BitWidth             = 8,
   parameter int Depth                = 16,
   parameter int AW                   = 4,
   parameter bit RegisteredRead       = 1'b1,
   parameter bit InvertedDisabledDOUT = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic                rEn,
   input  logic [AW-1:0]       rAddr,
   input  logic                busy,
   input  logic [BitWidth-1:0] rdWord,
   input  logic                wFire,
   input  logic [AW-1:0]       wAddr,
   input  logic [BitWidth-1:0] wMerged,
   output logic [BitWidth-1:0] dOUT
);

   localparam logic [BitWidth-1:0] DV = BitWidth'(disabled_value(InvertedDisabledDOUT, BitWidth));

   logic                readOk;
   logic [BitWidth-1:0] dComb;
   logic [BitWidth-1:0] dReg;

   assign readOk = rEn && !busy && (32'(rAddr) < Depth);
   assign dComb  = readOk ? rdWord : DV;

   // A write landing on the same edge wins, so the register sees the merged word.
   always_ff @(posedge clk) begin
      if (rst) begin
         dReg <= DV;
      end else if (clk_en) begin
         if (readOk && wFire && (wAddr == rAddr)) dReg <= wMerged;
         else                                     dReg <= dComb;
      end
   end

   assign dOUT = RegisteredRead ? dReg : dComb;

endmodule

// File: rtl/multi_read_mem.sv
// Register-file memory with one lane-masked write port, NumReadPorts read ports and a post-reset clear FSM.
module multi_read_mem import mem_pkg::*; #(
   parameter int BitWidth             = 8,
   parameter int Depth                = 16,
   parameter int NumReadPorts         = 2,
   parameter int LaneWidth            = 8,
   parameter bit RegisteredRead       = 1'b1,
   parameter bit InvertedDisabledDOUT = 1'b0,
   parameter bit ClearOnReset         = 1'b1
) (
   input logic             clk,
   input logic             rst,
   input logic             clk_en,
   multi_read_mem_if.slave bus
);

   localparam int AW       = addr_width(Depth);
   localparam int NumLanes = BitWidth / LaneWidth;

   if (BitWidth % LaneWidth != 0) begin : gBadLane
      $fatal(1, "multi_read_mem: BitWidth must be a multiple of LaneWidth");
   end
   if (NumReadPorts < 1) begin : gBadPorts
      $fatal(1, "multi_read_mem: NumReadPorts must be at least 1");
   end
   if (Depth < 1) begin : gBadDepth
      $fatal(1, "multi_read_mem: Depth must be at least 1");
   end

   logic [BitWidth-1:0]                   mem [Depth];
   clearState_t                           state;
   logic [AW-1:0]                         clearCnt;
   logic                                  wInRange;
   logic                                  wFire;
   logic [BitWidth-1:0]                   wOld;
   logic [BitWidth-1:0]                   wMerged;
   logic [NumReadPorts-1:0][BitWidth-1:0] rdWord;
   logic [NumReadPorts-1:0][BitWidth-1:0] dOutAll;

   assign bus.busy = (state == CLEAR);
   assign wInRange = 32'(bus.wAddr) < Depth;
   assign wFire    = bus.wEn && wInRange && (state == IDLE) && !rst;

   always_comb begin
      wOld    = wInRange ? mem[bus.wAddr] : '0;
      wMerged = wOld;
      for (int i = 0; i < NumLanes; i++) begin
         if (bus.wMask[i]) wMerged[i*LaneWidth +: LaneWidth] = bus.dIN[i*LaneWidth +: LaneWidth];
      end
   end

   // The clear walks the array once, handing back to IDLE on the edge that zeroes the last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ClearOnReset ? CLEAR : IDLE;
         clearCnt <= '0;
      end else if (clk_en && (state == CLEAR)) begin
         if (clearCnt == AW'(Depth - 1)) begin
            state    <= IDLE;
            clearCnt <= '0;
         end else begin
            clearCnt <= clearCnt + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clk_en && !rst) begin
         if (state == CLEAR) mem[clearCnt]  <= '0;
         else if (wFire)     mem[bus.wAddr] <= wMerged;
      end
   end

   always_comb begin
      for (int p = 0; p < NumReadPorts; p++) begin
         rdWord[p] = (32'(bus.rAddr[p]) < Depth) ? mem[bus.rAddr[p]] : '0;
      end
   end

   for (genvar p = 0; p < NumReadPorts; p++) begin : gPort
      mem_read_port #(
         .BitWidth             (BitWidth),
         .Depth                (Depth),
         .AW                   (AW),
         .RegisteredRead       (RegisteredRead),
         .InvertedDisabledDOUT (InvertedDisabledDOUT)
      ) uPort (
         .clk     (clk),
         .rst     (rst),
         .clk_en  (clk_en),
         .rEn     (bus.rEn[p]),
         .rAddr   (bus.rAddr[p]),
         .busy    (bus.busy),
         .rdWord  (rdWord[p]),
         .wFire   (wFire),
         .wAddr   (bus.wAddr),
         .wMerged (wMerged),
         .dOUT    (dOutAll[p])
      );
   end

   assign bus.dOUT = dOutAll;

endmodule
